// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory address/data, decode back-pressure,
// execute redirect, and the instruction register presented to decode.
interface instruction_fetch_if;
  // Instruction memory side
  logic [31:0] instruction_address;
  logic [31:0] instruction_data_input;

  // Control from decode / execute
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  // Presented to decode
  logic [31:0] fetched_instruction;
  logic [31:0] fetched_pc;
  logic        fetch_valid;
  logic        halted;
  logic        fetch_error;

  // The fetch unit itself
  modport master (
    output instruction_address,
    input  instruction_data_input,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output fetched_instruction,
    output fetched_pc,
    output fetch_valid,
    output halted,
    output fetch_error
  );

  // Memory, decode and execute surrounding the fetch unit
  modport slave (
    input  instruction_address,
    output instruction_data_input,
    output stall,
    output branch_taken,
    output branch_target,
    input  fetched_instruction,
    input  fetched_pc,
    input  fetch_valid,
    input  halted,
    input  fetch_error
  );
endinterface

// File: rtl/instruction_fetch.sv
// Program counter and fetch stage. Drives the instruction memory address from
// the PC, latches the returned word into the instruction register, and handles
// stalls, branch redirects, HALT detection and out-of-range fetch errors.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [4:0]  HALT_OPCODE  = 5'b00110,
  parameter int unsigned MEMORY_DEPTH = 31
) (
  input  logic           clock,
  input  logic           reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] fetched_pc_q, fetched_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        halted_q, halted_d;
  logic        fetch_error_q, fetch_error_d;

  logic        pc_in_range;
  logic        is_halt_word;
  logic [31:0] pc_plus_one;

  // Decode the current fetch: address range check, HALT opcode, sequential PC
  always_comb begin
    pc_in_range  = (pc_q < MEMORY_DEPTH);
    is_halt_word = (bus.instruction_data_input[31:27] == HALT_OPCODE);
    pc_plus_one  = pc_q + 32'd1;
  end

  // State register: synchronous reset wins over everything else
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= STATE_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      fetched_pc_q  <= 32'd0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      fetched_pc_q  <= fetched_pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  // Next-state logic: branch beats stall beats normal fetch; everything holds by default
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    fetched_pc_d  = fetched_pc_q;
    fetch_valid_d = fetch_valid_q;
    halted_d      = halted_q;
    fetch_error_d = fetch_error_q;

    case (state_q)
      STATE_IDLE: begin
        // One settling cycle for the memory; redirects and stalls are ignored
        state_d       = STATE_RUN;
        fetch_valid_d = 1'b0;
      end

      STATE_RUN: begin
        if (bus.branch_taken) begin
          pc_d          = bus.branch_target;
          fetch_valid_d = 1'b0;
          halted_d      = 1'b0;
          state_d       = STATE_RUN;
        end else if (bus.stall) begin
          state_d = STATE_RUN;
        end else if (!pc_in_range) begin
          fetch_valid_d = 1'b0;
          fetch_error_d = 1'b1;
          halted_d      = 1'b1;
          state_d       = STATE_HALT;
        end else begin
          ir_d          = bus.instruction_data_input;
          fetched_pc_d  = pc_q;
          fetch_valid_d = 1'b1;
          if (is_halt_word) begin
            halted_d = 1'b1;
            state_d  = STATE_HALT;
          end else begin
            pc_d = pc_plus_one;
          end
        end
      end

      STATE_HALT: begin
        if (bus.branch_taken) begin
          // A HALT fetched on a wrong path is cancelled by the late redirect
          pc_d          = bus.branch_target;
          fetch_valid_d = 1'b0;
          halted_d      = 1'b0;
          state_d       = STATE_RUN;
        end else if (bus.stall) begin
          state_d = STATE_HALT;
        end else begin
          // Decode has consumed the HALT instruction; nothing more to offer
          fetch_valid_d = 1'b0;
          state_d       = STATE_HALT;
        end
      end

      default: begin
        state_d       = STATE_IDLE;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers; the memory address is the PC itself
  always_comb begin
    bus.instruction_address = pc_q;
    bus.fetched_instruction = ir_q;
    bus.fetched_pc          = fetched_pc_q;
    bus.fetch_valid         = fetch_valid_q;
    bus.halted              = halted_q;
    bus.fetch_error         = fetch_error_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for the main run plus
// hand-written sequences for HALT stalls, out-of-range fetch and mid-run reset.
module tb_instruction_fetch;

  localparam logic [31:0] HALT_WORD = 32'h3000_0000;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] fpc;
    logic        valid;
    logic        halted;
    logic        err;
  } vec_t;

  logic clock;
  logic reset;
  int   vectors_applied;
  int   miscompares;
  vec_t vecs[$];

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC     (32'd0),
    .HALT_OPCODE  (5'b00110),
    .MEMORY_DEPTH (31)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Ordinary instruction words carry their own address so captures are traceable
  function automatic logic [31:0] word(input int k);
    return {5'b00001, 27'(k)};
  endfunction

  // Instruction memory model: word 26 is HALT, everything else ordinary
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd26) return HALT_WORD;
    else if (a < 32'd64) return word(int'(a));
    else return 32'd0;
  endfunction

  assign bus.instruction_data_input = mem_word(bus.instruction_address);

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic [31:0] tgt, input logic [31:0] addr,
                              input logic [31:0] ir, input logic [31:0] fpc,
                              input logic valid, input logic halted, input logic err);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
    v.addr = addr; v.ir = ir; v.fpc = fpc;
    v.valid = valid; v.halted = halted; v.err = err;
    return v;
  endfunction

  // Drive one cycle of inputs away from the edge, then sample just after it
  task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                               input logic [31:0] tgt);
    @(negedge clock);
    reset            = rst;
    bus.stall        = stall;
    bus.branch_taken = br;
    bus.branch_target = tgt;
    @(posedge clock);
    #1;
    vectors_applied++;
  endtask

  task automatic compareField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got %h expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] addr,
                             input logic [31:0] ir, input logic [31:0] fpc,
                             input logic valid, input logic halted, input logic err);
    compareField(name, "instruction_address", bus.instruction_address, addr);
    compareField(name, "fetched_instruction", bus.fetched_instruction, ir);
    compareField(name, "fetched_pc",          bus.fetched_pc,          fpc);
    compareField(name, "fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, valid});
    compareField(name, "halted",      {31'd0, bus.halted},      {31'd0, halted});
    compareField(name, "fetch_error", {31'd0, bus.fetch_error}, {31'd0, err});
  endtask

  initial begin
    vectors_applied   = 0;
    miscompares       = 0;
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;

    // Reset two cycles, then IDLE ignores a stall+branch, then words 0..2
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 9,  0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, word(0), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  2, word(1), 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  3, word(2), 2, 1, 0, 0));
    // Three stall cycles hold everything with fetched_pc=2
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 0, 3, word(2), 2, 1, 0, 0));
    // Resume with word 3 and run up to PC=24
    for (int k = 3; k <= 23; k++)
      vecs.push_back(mk(0, 0, 0, 0, 32'(k + 1), word(k), 32'(k), 1, 0, 0));
    // Branch to 17 overrides a simultaneous stall and squashes the IR
    vecs.push_back(mk(0, 1, 1, 17, 17, word(23), 23, 0, 0, 0));
    for (int k = 17; k <= 25; k++)
      vecs.push_back(mk(0, 0, 0, 0, 32'(k + 1), word(k), 32'(k), 1, 0, 0));
    // HALT at 26: valid for one cycle, then held halted with PC parked
    vecs.push_back(mk(0, 0, 0, 0, 26, HALT_WORD, 26, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 26, HALT_WORD, 26, 0, 1, 0));
    // Branch out of HALT to 5, then word 5 fetched normally
    vecs.push_back(mk(0, 0, 1, 5, 5, HALT_WORD, 26, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 6, word(5),   5,  1, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      checkOutput($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ir, vecs[i].fpc,
                  vecs[i].valid, vecs[i].halted, vecs[i].err);
    end

    // HALT reached while decode stalls keeps the HALT instruction valid
    applyStimulus(0, 0, 1, 25);  checkOutput("br25",       25, word(5),   5,  0, 0, 0);
    applyStimulus(0, 0, 0, 0);   checkOutput("fetch25",    26, word(25),  25, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);   checkOutput("halt_cap",   26, HALT_WORD, 26, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);   checkOutput("halt_stall", 26, HALT_WORD, 26, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);   checkOutput("halt_stall", 26, HALT_WORD, 26, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);   checkOutput("halt_drop",  26, HALT_WORD, 26, 0, 1, 0);
    applyStimulus(0, 1, 1, 27);  checkOutput("halt_brst", 27, HALT_WORD, 26, 0, 0, 0);

    // Run off the end of memory: word 30 captured, then PC=31 is an error
    for (int k = 27; k <= 30; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("fetch_hi", 32'(k + 1), word(k), 32'(k), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0);   checkOutput("oor",        31, word(30), 30, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);   checkOutput("oor_hold",   31, word(30), 30, 0, 1, 1);
    applyStimulus(0, 0, 1, 2);   checkOutput("err_br",     2,  word(30), 30, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);   checkOutput("err_sticky", 3,  word(2),  2,  1, 0, 1);

    // Reset mid-run clears everything on the next edge, then fetching restarts
    applyStimulus(1, 0, 0, 0);   checkOutput("mid_reset",  0, 0,       0, 0, 0, 0);
    applyStimulus(1, 1, 1, 12);  checkOutput("reset_ovr",  0, 0,       0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);   checkOutput("idle2",      0, 0,       0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);   checkOutput("restart",    1, word(0), 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
